// File: rtl/eq_gain_sequencer.sv
// Six-band equalizer gain sequencer: key pulses edit per-band signed steps and
// changed bands are programmed into the DSP inside the window after its done pulse.
//
// state  | meaning
// S_INIT | one cycle after reset before the first sweep
// S_PICK | choose lowest dirty band, or go idle
// S_IDLE | nothing dirty, waiting for a key
// S_WAIT | waiting for dsp_done window (or timeout)
// S_SET  | o_set_gain/o_gain held for HOLD_CYC cycles
// S_GAP  | one cycle with o_set_gain released
module eq_gain_sequencer #(
   parameter logic [15:0] STEP_DB  = 16'h0200,
   parameter int          MAX_STEP = 6,
   parameter int          HOLD_CYC = 4,
   parameter int          TIMEOUT  = 4096
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_band_up,
   input  logic        i_band_dn,
   input  logic        i_gain_up,
   input  logic        i_gain_dn,
   input  logic        i_flat,
   input  logic        i_dsp_done,
   output logic [15:0] o_gain,
   output logic [2:0]  o_set_gain,
   output logic [2:0]  o_sel_band,
   output logic [3:0]  o_sel_step,
   output logic        o_busy
);

   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int HOLD_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
   localparam logic signed [3:0] STEP_MAX = 4'(MAX_STEP);
   localparam logic signed [3:0] STEP_MIN = -STEP_MAX;

   typedef enum logic [2:0] {S_INIT, S_PICK, S_IDLE, S_WAIT, S_SET, S_GAP} state_t;

   state_t            state;
   logic              first_sweep;
   logic signed [3:0] steps [6];
   logic [5:0]        dirty;
   logic [2:0]        sel_band;
   logic [2:0]        cur_band;
   logic [WAIT_W-1:0] wait_cnt;
   logic [HOLD_W-1:0] hold_cnt;

   logic [2:0]        sel_idx, pick_idx, set_band, set_idx;
   logic signed [3:0] sel_step, set_step;
   logic              inc, dec, enter_set;
   logic [5:0]        key_dirty, clr_dirty;
   logic [15:0]       set_gain_val;

   always_comb begin
      pick_idx = 3'd0;
      for (int i = 5; i >= 0; i--)
         if (dirty[i]) pick_idx = 3'(i);
   end

   assign sel_idx   = sel_band - 3'd1;
   assign sel_step  = steps[sel_idx];
   assign inc       = i_gain_up & ~i_gain_dn & ~i_flat & (sel_step < STEP_MAX);
   assign dec       = i_gain_dn & ~i_gain_up & ~i_flat & (sel_step > STEP_MIN);
   assign key_dirty = (inc | dec) ? (6'd1 << sel_idx) : 6'd0;

   // The write target is chosen in S_PICK; in S_WAIT it was already latched.
   assign enter_set = (state == S_PICK && dirty != 6'd0 && first_sweep) ||
                      (state == S_WAIT && (i_dsp_done || wait_cnt == '0));
   assign set_band     = (state == S_PICK) ? pick_idx + 3'd1 : cur_band;
   assign set_idx      = set_band - 3'd1;
   assign set_step     = steps[set_idx];
   assign set_gain_val = 16'(set_step) * STEP_DB;
   assign clr_dirty    = enter_set ? (6'd1 << set_idx) : 6'd0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 6; i++) steps[i] <= 4'sd0;
         sel_band <= 3'd1;
      end else begin
         if (i_flat) begin
            for (int i = 0; i < 6; i++) steps[i] <= 4'sd0;
         end else if (inc) begin
            steps[sel_idx] <= sel_step + 4'sd1;
         end else if (dec) begin
            steps[sel_idx] <= sel_step - 4'sd1;
         end
         if (i_band_up && !i_band_dn)
            sel_band <= (sel_band == 3'd6) ? 3'd1 : sel_band + 3'd1;
         else if (i_band_dn && !i_band_up)
            sel_band <= (sel_band == 3'd1) ? 3'd6 : sel_band - 3'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_INIT;
         first_sweep <= 1'b1;
         dirty       <= 6'h3F;
         cur_band    <= 3'd1;
         wait_cnt    <= '0;
         hold_cnt    <= '0;
         o_gain      <= 16'd0;
         o_set_gain  <= 3'd0;
      end else begin
         // A key landing on the band being latched re-marks it for a later rewrite.
         dirty <= i_flat ? 6'h3F : ((dirty & ~clr_dirty) | key_dirty);
         if (enter_set) begin
            state      <= S_SET;
            cur_band   <= set_band;
            o_gain     <= set_gain_val;
            o_set_gain <= set_band;
            hold_cnt   <= HOLD_W'(HOLD_CYC - 1);
         end else begin
            case (state)
               S_INIT: state <= S_PICK;
               S_PICK: begin
                  if (dirty == 6'd0) begin
                     state       <= S_IDLE;
                     first_sweep <= 1'b0;
                  end else begin
                     state    <= S_WAIT;
                     cur_band <= pick_idx + 3'd1;
                     wait_cnt <= WAIT_W'(TIMEOUT - 1);
                  end
               end
               S_IDLE: if (dirty != 6'd0) state <= S_PICK;
               S_WAIT: wait_cnt <= wait_cnt - 1'b1;
               S_SET: begin
                  if (hold_cnt == '0) begin
                     state      <= S_GAP;
                     o_set_gain <= 3'd0;
                  end else begin
                     hold_cnt <= hold_cnt - 1'b1;
                  end
               end
               S_GAP:   state <= S_PICK;
               default: state <= S_INIT;
            endcase
         end
      end
   end

   assign o_sel_band = sel_band;
   assign o_sel_step = sel_step;
   assign o_busy     = (state != S_IDLE) || (dirty != 6'd0);

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// Directed bench for eq_gain_sequencer: a monitor logs every write burst and
// each scenario task compares the log and outputs against hand-computed values.
module tb_eq_gain_sequencer;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        band_up = 0, band_dn = 0, gain_up = 0, gain_dn = 0, flat = 0, dsp_done = 0;
   logic [15:0] o_gain;
   logic [2:0]  o_set_gain, o_sel_band;
   logic [3:0]  o_sel_step;
   logic        o_busy;

   int vectors = 0, miscompares = 0, cyc = 0;

   eq_gain_sequencer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_band_up(band_up), .i_band_dn(band_dn),
      .i_gain_up(gain_up), .i_gain_dn(gain_dn), .i_flat(flat), .i_dsp_done(dsp_done),
      .o_gain(o_gain), .o_set_gain(o_set_gain), .o_sel_band(o_sel_band),
      .o_sel_step(o_sel_step), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  band;
      logic [15:0] gain;
      int          len;
      int          start;
      bit          stable;
   } wr_t;

   wr_t        wq[$];
   wr_t        cur;
   logic [2:0] cur_b = 3'd0;

   always @(negedge clk) begin
      cyc++;
      if (o_set_gain != 3'd0 && o_set_gain == cur_b) begin
         cur.len++;
         if (o_gain !== cur.gain) cur.stable = 1'b0;
      end else begin
         if (cur_b != 3'd0) wq.push_back(cur);
         cur_b = o_set_gain;
         if (o_set_gain != 3'd0) begin
            cur.band = o_set_gain; cur.gain = o_gain; cur.len = 1;
            cur.start = cyc; cur.stable = 1'b1;
         end
      end
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic pulse(input bit bu, input bit bd, input bit gu, input bit gd,
                        input bit fl, input bit dd);
      band_up = bu; band_dn = bd; gain_up = gu; gain_dn = gd; flat = fl; dsp_done = dd;
      tick();
      band_up = 0; band_dn = 0; gain_up = 0; gain_dn = 0; flat = 0; dsp_done = 0;
      tick();
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (o_busy === 1'b0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      tick(); tick();
      vectors++; if (o_set_gain !== 3'd0) begin miscompares++; $display("FAIL reset_set_gain: got %0d expected 0", o_set_gain); end
      vectors++; if (o_gain !== 16'h0000) begin miscompares++; $display("FAIL reset_gain: got %h expected 0000", o_gain); end
      vectors++; if (o_sel_band !== 3'd1) begin miscompares++; $display("FAIL reset_sel_band: got %0d expected 1", o_sel_band); end
      vectors++; if (o_sel_step !== 4'd0) begin miscompares++; $display("FAIL reset_sel_step: got %0d expected 0", o_sel_step); end
      vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b expected 1", o_busy); end
   endtask

   task automatic check_sweep(input string tag);
      bit ok;
      int g;
      wait_idle(300, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL %s_idle: busy never dropped", tag); end
      vectors++; if (wq.size() != 6) begin miscompares++; $display("FAIL %s_count: got %0d writes expected 6", tag, wq.size()); end
      for (int i = 0; i < 6 && i < wq.size(); i++) begin
         vectors++; if (wq[i].band !== 3'(i + 1)) begin miscompares++; $display("FAIL %s_band%0d: got %0d expected %0d", tag, i, wq[i].band, i + 1); end
         vectors++; if (wq[i].gain !== 16'h0000 || !wq[i].stable) begin miscompares++; $display("FAIL %s_gain%0d: got %h expected 0000", tag, i, wq[i].gain); end
         vectors++; if (wq[i].len != 4) begin miscompares++; $display("FAIL %s_len%0d: got %0d expected 4", tag, i, wq[i].len); end
         if (i > 0) begin
            g = wq[i].start - (wq[i-1].start + wq[i-1].len);
            vectors++; if (g < 1 || g > 2) begin miscompares++; $display("FAIL %s_gap%0d: got %0d expected 1..2", tag, i, g); end
         end
      end
   endtask

   task automatic test_init_sweep();
      wq.delete();
      rst_n = 1'b1;
      check_sweep("sweep");
   endtask

   task automatic test_band_gain();
      bit ok;
      int t0;
      wq.delete();
      pulse(1,0,0,0,0,0); pulse(1,0,0,0,0,0);
      vectors++; if (o_sel_band !== 3'd3) begin miscompares++; $display("FAIL bg_sel_band: got %0d expected 3", o_sel_band); end
      pulse(0,0,1,0,0,0); pulse(0,0,1,0,0,0); pulse(0,0,1,0,0,0);
      vectors++; if (o_sel_step !== 4'd3) begin miscompares++; $display("FAIL bg_sel_step: got %0d expected 3", o_sel_step); end
      tick(); tick(); tick();
      vectors++; if (wq.size() != 0 || o_set_gain !== 3'd0 || o_busy !== 1'b1) begin miscompares++; $display("FAIL bg_no_window: got writes=%0d busy=%b expected 0 and 1", wq.size(), o_busy); end
      t0 = cyc;
      pulse(0,0,0,0,0,1);
      wait_idle(50, ok);
      vectors++; if (!ok || wq.size() != 1) begin miscompares++; $display("FAIL bg_count: got %0d writes expected 1", wq.size()); end
      else begin
         vectors++; if (wq[0].band !== 3'd3 || wq[0].gain !== 16'h0600 || !wq[0].stable) begin miscompares++; $display("FAIL bg_write: got band %0d gain %h expected 3 0600", wq[0].band, wq[0].gain); end
         vectors++; if (wq[0].start != t0 + 1 || wq[0].len != 4) begin miscompares++; $display("FAIL bg_timing: got start %0d len %0d expected %0d 4", wq[0].start, wq[0].len, t0 + 1); end
      end
   endtask

   task automatic test_saturate();
      bit ok;
      int t0;
      pulse(0,1,0,0,0,0); pulse(0,1,0,0,0,0);
      vectors++; if (o_sel_band !== 3'd1 || o_sel_step !== 4'd0) begin miscompares++; $display("FAIL sat_sel: got band %0d step %0d expected 1 0", o_sel_band, o_sel_step); end
      wq.delete();
      for (int i = 0; i < 8; i++) pulse(0,0,0,1,0,0);
      vectors++; if (o_sel_step !== 4'hA) begin miscompares++; $display("FAIL sat_step: got %h expected a", o_sel_step); end
      tick(); tick();
      t0 = cyc;
      pulse(0,0,0,0,0,1);
      wait_idle(50, ok);
      vectors++; if (!ok || wq.size() != 1) begin miscompares++; $display("FAIL sat_count: got %0d writes expected 1", wq.size()); end
      else begin
         vectors++; if (wq[0].band !== 3'd1 || wq[0].gain !== 16'hF400 || wq[0].start != t0 + 1) begin miscompares++; $display("FAIL sat_write: got band %0d gain %h start %0d expected 1 f400 %0d", wq[0].band, wq[0].gain, wq[0].start, t0 + 1); end
      end
      wq.delete();
      pulse(0,0,0,1,0,0); pulse(0,0,0,1,0,0);
      vectors++; if (o_busy !== 1'b0 || o_sel_step !== 4'hA) begin miscompares++; $display("FAIL sat_extra: got busy %b step %h expected 0 a", o_busy, o_sel_step); end
      pulse(0,0,0,0,0,1);
      for (int i = 0; i < 6; i++) tick();
      vectors++; if (wq.size() != 0) begin miscompares++; $display("FAIL sat_no_write: got %0d writes expected 0", wq.size()); end
   endtask

   task automatic test_band_wrap();
      pulse(0,1,0,0,0,0);
      vectors++; if (o_sel_band !== 3'd6) begin miscompares++; $display("FAIL wrap_dn: got %0d expected 6", o_sel_band); end
      pulse(1,0,0,0,0,0);
      vectors++; if (o_sel_band !== 3'd1) begin miscompares++; $display("FAIL wrap_up: got %0d expected 1", o_sel_band); end
      pulse(1,1,0,0,0,0);
      vectors++; if (o_sel_band !== 3'd1) begin miscompares++; $display("FAIL wrap_both: got %0d expected 1", o_sel_band); end
      pulse(0,0,1,1,0,0);
      vectors++; if (o_sel_step !== 4'hA || o_busy !== 1'b0) begin miscompares++; $display("FAIL gain_both: got step %h busy %b expected a 0", o_sel_step, o_busy); end
   endtask

   task automatic test_rewrite();
      bit ok;
      int t0;
      pulse(1,0,0,0,0,0);
      pulse(0,0,1,0,0,0);
      vectors++; if (o_sel_band !== 3'd2 || o_sel_step !== 4'd1) begin miscompares++; $display("FAIL rw_sel: got band %0d step %0d expected 2 1", o_sel_band, o_sel_step); end
      tick(); tick(); tick();
      wq.delete();
      t0 = cyc;
      dsp_done = 1'b1; tick(); dsp_done = 1'b0;
      vectors++; if (o_set_gain !== 3'd2) begin miscompares++; $display("FAIL rw_first_start: got %0d expected 2", o_set_gain); end
      pulse(0,0,1,0,0,0);
      for (int i = 0; i < 10 && o_set_gain != 3'd0; i++) tick();
      tick(); tick(); tick();
      vectors++; if (o_busy !== 1'b1 || o_set_gain !== 3'd0 || o_sel_step !== 4'd2) begin miscompares++; $display("FAIL rw_pending: got busy %b set %0d step %0d expected 1 0 2", o_busy, o_set_gain, o_sel_step); end
      pulse(0,0,0,0,0,1);
      wait_idle(50, ok);
      vectors++; if (!ok || wq.size() != 2) begin miscompares++; $display("FAIL rw_count: got %0d writes expected 2", wq.size()); end
      else begin
         vectors++; if (wq[0].band !== 3'd2 || wq[0].gain !== 16'h0200 || !wq[0].stable || wq[0].len != 4 || wq[0].start != t0 + 1) begin miscompares++; $display("FAIL rw_first: got band %0d gain %h len %0d expected 2 0200 4", wq[0].band, wq[0].gain, wq[0].len); end
         vectors++; if (wq[1].band !== 3'd2 || wq[1].gain !== 16'h0400 || !wq[1].stable || wq[1].len != 4) begin miscompares++; $display("FAIL rw_second: got band %0d gain %h len %0d expected 2 0400 4", wq[1].band, wq[1].gain, wq[1].len); end
      end
   endtask

   task automatic test_flat();
      bit ok;
      pulse(0,0,1,0,1,0);
      vectors++; if (o_sel_step !== 4'd0 || o_busy !== 1'b1) begin miscompares++; $display("FAIL flat_state: got step %0d busy %b expected 0 1", o_sel_step, o_busy); end
      wq.delete();
      dsp_done = 1'b1;
      wait_idle(100, ok);
      dsp_done = 1'b0;
      vectors++; if (!ok || wq.size() != 6) begin miscompares++; $display("FAIL flat_count: got %0d writes expected 6", wq.size()); end
      for (int i = 0; i < wq.size() && i < 6; i++) begin
         vectors++; if (wq[i].band !== 3'(i + 1) || wq[i].gain !== 16'h0000) begin miscompares++; $display("FAIL flat_write%0d: got band %0d gain %h expected %0d 0000", i, wq[i].band, wq[i].gain, i + 1); end
      end
   endtask

   task automatic test_timeout_reset();
      int t0;
      bit seen;
      wq.delete();
      t0 = cyc;
      pulse(0,0,1,0,0,0);
      seen = 1'b0;
      for (int i = 0; i < 4300; i++) begin
         if (o_set_gain != 3'd0) begin seen = 1'b1; break; end
         tick();
      end
      vectors++; if (!seen) begin miscompares++; $display("FAIL to_write: got no write expected one after timeout"); end
      else begin
         vectors++; if (cyc != t0 + 4099) begin miscompares++; $display("FAIL to_latency: got cycle %0d expected %0d", cyc, t0 + 4099); end
         vectors++; if (o_set_gain !== 3'd2 || o_gain !== 16'h0200) begin miscompares++; $display("FAIL to_value: got band %0d gain %h expected 2 0200", o_set_gain, o_gain); end
      end
      tick();
      rst_n = 1'b0;
      #1;
      vectors++; if (o_set_gain !== 3'd0) begin miscompares++; $display("FAIL rst_abort: got %0d expected 0", o_set_gain); end
      vectors++; if (o_gain !== 16'h0000 || o_sel_band !== 3'd1 || o_sel_step !== 4'd0 || o_busy !== 1'b1) begin miscompares++; $display("FAIL rst_state: got gain %h band %0d step %0d busy %b expected 0000 1 0 1", o_gain, o_sel_band, o_sel_step, o_busy); end
      tick(); tick();
      wq.delete();
      rst_n = 1'b1;
      check_sweep("resweep");
   endtask

   initial begin
      test_reset();
      test_init_sweep();
      test_band_gain();
      test_saturate();
      test_band_wrap();
      test_rewrite();
      test_flat();
      test_timeout_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
